// File: rtl/xs3_bcd_to_binary_seq_pkg.sv
// rtl/xs3_bcd_to_binary_seq_pkg.sv - Excess-3 constants, FSM state type and result-width helper
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'h3;
    localparam logic [3:0] XS3_MAX    = 4'hC;

    typedef enum logic [1:0] {IDLE, CONV, DONE} xs3_state_t;

    // Smallest w with 2**w >= 10**digits.
    function automatic int min_bin_w(input int digits);
        longint p;
        int     w;
        p = 1;
        for (int i = 0; i < digits && i < 18; i++) p = p * 10;
        w = 0;
        for (int i = 0; i < 63; i++) if ((longint'(1) << i) < p) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/xs3_bcd_to_binary_seq_if.sv
// rtl/xs3_bcd_to_binary_seq_if.sv - input/output handshake bundle of the Excess-3 to binary converter
interface xs3_bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   excess3;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      binary;
    logic                  err;
    logic                  busy;

    modport master (
        output in_valid, excess3, out_ready,
        input  in_ready, out_valid, binary, err, busy
    );

    modport slave (
        input  in_valid, excess3, out_ready,
        output in_ready, out_valid, binary, err, busy
    );
endinterface

// File: rtl/xs3_bcd_to_binary_seq_digit_decode.sv
// rtl/xs3_bcd_to_binary_seq_digit_decode.sv - single Excess-3 digit to value plus in-range flag
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] xs3_i,
    output logic [3:0] value_o,
    output logic       valid_o
);
    assign value_o = xs3_i - XS3_OFFSET;
    assign valid_o = (xs3_i >= XS3_MIN) && (xs3_i <= XS3_MAX);
endmodule

// File: rtl/xs3_bcd_to_binary_seq.sv
// rtl/xs3_bcd_to_binary_seq.sv - MSD-first serial Excess-3 BCD to binary converter
// Optional: XS3_ERR_DETECT_EN enables the invalid-digit flag and zeroes the result on error.
module xs3_bcd_to_binary_seq
    import xs3_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input logic                    clk,
    input logic                    rst_n,
    xs3_bcd_to_binary_seq_if.slave io
);
    localparam int SR_W  = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "xs3_bcd_to_binary_seq: DIGITS out of range 1..8");
    end
    if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
        $fatal(1, "xs3_bcd_to_binary_seq: BIN_W too small for DIGITS");
    end

    xs3_state_t        state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [BIN_W-1:0]  acc_q, acc_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        msd, dig_val;
    logic              dig_ok;
    logic signed [4:0] delta5;
    logic [BIN_W-1:0]  acc_step;
    logic              accept, last_digit, release_w;

    assign msd = sr_q[SR_W-1 -: 4];

    xs3_digit_decode u_dec (
        .xs3_i   (msd),
        .value_o (dig_val),
        .valid_o (dig_ok)
    );

    // Invalid digits below 3 borrow, so the step is a signed 5-bit (d - 3).
    assign delta5   = {~dig_ok & ~msd[3], dig_val};
    assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(delta5);

    assign accept     = (state_q == IDLE) && io.in_valid;
    assign last_digit = (state_q == CONV) && (cnt_q == LAST_CNT);
    assign release_w  = (state_q == DONE) && io.out_ready;

`ifdef XS3_ERR_DETECT_EN
    logic err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = CONV;
            CONV:    if (last_digit) state_d = DONE;
            DONE:    if (release_w)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == DONE);
        io.busy      = (state_q == CONV) || (state_q == DONE);
    end

    always_comb begin
        sr_d  = sr_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        bin_d = bin_q;
`ifdef XS3_ERR_DETECT_EN
        err_d = err_q;
`endif
        if (accept) begin
            sr_d  = io.excess3;
            acc_d = '0;
            cnt_d = '0;
`ifdef XS3_ERR_DETECT_EN
            err_d = 1'b0;
`endif
        end else if (state_q == CONV) begin
            sr_d  = sr_q << 4;
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
`ifdef XS3_ERR_DETECT_EN
            err_d = err_q | ~dig_ok;
            if (last_digit) bin_d = err_d ? '0 : acc_step;
`else
            if (last_digit) bin_d = acc_step;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            bin_q <= '0;
        end else begin
            sr_q  <= sr_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            bin_q <= bin_d;
        end
    end

`ifdef XS3_ERR_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign io.err = err_q;
`else
    assign io.err = 1'b0;
`endif

    assign io.binary = bin_q;

endmodule

// File: tb/tb_xs3_bcd_to_binary_seq.sv
// tb/tb_xs3_bcd_to_binary_seq.sv - scoreboard bench for xs3_bcd_to_binary_seq (DIGITS=3, BIN_W=10)
module tb_xs3_bcd_to_binary_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xs3_bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    xs3_bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } res_t;

    res_t exp_q[$];
    int   lat_q[$];
    int   hs_cyc[$];
    res_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: MSD-first acc*10 + (d-3), wrapped to BIN_W bits.
    function automatic res_t model(input logic [4*DIGITS-1:0] w);
        res_t       r;
        int         acc;
        logic [3:0] d;
        bit         e;
        acc = 0;
        e   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d   = w[4*i +: 4];
            if (d < 4'h3 || d > 4'hC) e = 1'b1;
            acc = (acc * 10 + (int'(d) - 3)) & ((1 << BIN_W) - 1);
        end
`ifdef XS3_ERR_DETECT_EN
        if (e) acc = 0;
        r.err = e;
`else
        r.err = 1'b0 & e;
`endif
        r.bin = acc[BIN_W-1:0];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) lat_q.push_back(cyc + 1);
        if (bus.out_valid && !prev_valid) begin
            if (lat_q.size() > 0) check_val("latency", cyc - lat_q.pop_front(), DIGITS);
            else                  check_val("spurious_valid", 1, 0);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_val("binary", bus.binary, mon_e.bin);
                check_val("err", bus.err, mon_e.err);
                hs_cyc.push_back(cyc);
            end else begin
                check_val("unexpected_out", 1, 0);
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_val("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [11:0] w, input bit track);
        wait_ready();
        bus.excess3  = w;
        bus.in_valid = 1'b1;
        if (track) exp_q.push_back(model(w));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.excess3  = 12'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_val("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic hold_until_accepted();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (n >= 50) check_val("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.excess3   = '0;
        bus.out_ready = 1'b1;
        #1;
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_binary", bus.binary, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(12'h456, 1'b1);
        check_val("busy_conv", bus.busy, 1);
        check_val("in_ready_conv", bus.in_ready, 0);
        drain();
        check_val("in_ready_return", bus.in_ready, 1);

        send(12'h333, 1'b1); drain();
        send(12'hCCC, 1'b1); drain();
        send(12'h3A2, 1'b1); drain();

        // Backpressure: result must hold and no new word may be taken.
        bus.out_ready = 1'b0;
        send(12'h789, 1'b1);
        begin
            int n = 0;
            while (!bus.out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 20) check_val("stall_valid_timeout", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.excess3  = 12'h456;
            @(posedge clk); #1;
            check_val("stall_out_valid", bus.out_valid, 1);
            check_val("stall_binary", bus.binary, model(12'h789).bin);
            check_val("stall_err", bus.err, model(12'h789).err);
            check_val("stall_in_ready", bus.in_ready, 0);
            check_val("stall_busy", bus.busy, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("release_out_valid", bus.out_valid, 0);
        check_val("release_in_ready", bus.in_ready, 1);
        check_val("release_busy", bus.busy, 0);
        check_val("release_binary_kept", bus.binary, model(12'h789).bin);
        check_val("release_queue", exp_q.size(), 0);

        // Abort a word with reset in its second CONV cycle.
        send(12'h555, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", bus.in_ready, 1);
        check_val("abort_out_valid", bus.out_valid, 0);
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_binary", bus.binary, 0);
        check_val("abort_err", bus.err, 0);
        lat_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("abort_no_emit", bus.out_valid, 0);
        send(12'h444, 1'b1); drain();

        // Back-to-back with in_valid held high.
        bus.excess3  = 12'h456;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(12'h456));
        hold_until_accepted();
        bus.excess3 = 12'h4C4;
        exp_q.push_back(model(12'h4C4));
        hold_until_accepted();
        bus.in_valid = 1'b0;
        drain();
        if (hs_cyc.size() >= 2)
            check_val("b2b_spacing", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], DIGITS + 2);
        else
            check_val("b2b_count", hs_cyc.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
